// File: rtl/beat_interval_meter_pkg.sv
// Shared types and defaults for the beat interval meter.
package beat_interval_meter_pkg;

  // Default counter width, matching the countdown timer load width.
  localparam int unsigned BIM_WIDTH = 9;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } bim_state_e;

endpackage : beat_interval_meter_pkg

// File: rtl/beat_interval_meter_if.sv
// Beat strobe, event input and measurement results of the beat interval meter.
interface beat_interval_meter_if
  import beat_interval_meter_pkg::*;
#(
  parameter int unsigned WIDTH = BIM_WIDTH
) ();

  logic             count_en;
  logic             event_in;
  logic [WIDTH-1:0] interval;
  logic             interval_valid;
  logic             timeout;
  logic             busy;

  modport master (
    output count_en,
    output event_in,
    input  interval,
    input  interval_valid,
    input  timeout,
    input  busy
  );

  modport slave (
    input  count_en,
    input  event_in,
    output interval,
    output interval_valid,
    output timeout,
    output busy
  );

endinterface : beat_interval_meter_if

// File: rtl/beat_interval_meter_rise_detect.sv
// Turns a synchronous event level into a one-cycle rising-edge indication.
module beat_interval_meter_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic event_i,
  output logic rise_c_o
);

  logic event_q;

  // Previous-cycle copy of the event level.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= 1'b0;
    end else begin
      event_q <= event_i;
    end
  end

  assign rise_c_o = event_i & ~event_q;

endmodule : beat_interval_meter_rise_detect

// File: rtl/beat_interval_meter.sv
// Counts beat32 beats between successive accepted rising edges of an event.
module beat_interval_meter
  import beat_interval_meter_pkg::*;
#(
  parameter int unsigned WIDTH        = BIM_WIDTH,
  parameter int unsigned MIN_INTERVAL = 2,
  parameter int unsigned TIMEOUT      = 511
) (
  input  logic                  clk,
  input  logic                  reset,
  beat_interval_meter_if.slave  bus
);

  bim_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] interval_q, interval_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             rise_c;
  logic             accept_c;
  logic             last_beat_c;

  beat_interval_meter_rise_detect u_rise_detect (
    .clk      (clk),
    .reset    (reset),
    .event_i  (bus.event_in),
    .rise_c_o (rise_c)
  );

  // A rise is only an interval end once the pre-increment count reaches the glitch floor.
  assign accept_c    = rise_c && (count_q >= WIDTH'(MIN_INTERVAL));
  assign last_beat_c = (count_q + WIDTH'(1)) == WIDTH'(TIMEOUT);

  // Next-state, count and pulse logic; an accepted rise takes priority over the beat.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    interval_d = interval_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d = MEASURE;
          count_d = '0;
        end
      end
      MEASURE: begin
        if (accept_c) begin
          interval_d = count_q;
          valid_d    = 1'b1;
          count_d    = '0;
        end else if (bus.count_en) begin
          if (last_beat_c) begin
            state_d   = IDLE;
            count_d   = '0;
            timeout_d = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, count and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      interval_q <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      interval_q <= interval_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.interval       = interval_q;
  assign bus.interval_valid = valid_q;
  assign bus.timeout        = timeout_q;
  assign bus.busy           = (state_q == MEASURE);

endmodule : beat_interval_meter
